// File: rtl/intersect_seq_pkg.sv
// Shared types and window helpers for the intersect-window sequencing controller.
package intersect_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_B,
    ST_WAIT,
    ST_END,
    ST_GAP
  } seq_state_t;

  function automatic int unsigned win_lo(input int unsigned a_min, input int unsigned s_min);
    return (a_min > s_min) ? a_min : s_min;
  endfunction

  function automatic int unsigned win_hi(input int unsigned a_max, input int unsigned s_max);
    return (a_max < s_max) ? a_max : s_max;
  endfunction

  // An empty window (lo > hi) makes every delay illegal.
  function automatic logic dly_legal(input int unsigned d, input int unsigned lo,
                                     input int unsigned hi);
    return (d != 0) && (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 and wraps, one-hot grant.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW:0] cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = {1'b0, ptr} + (PW+1)'(off);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (en && !found && req[cand[PW-1:0]]) begin
        gnt[cand[PW-1:0]] = 1'b1;
        idx               = cand[PW-1:0];
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersect_seq_ctrl.sv
// Shares one start/b/a/stop channel among N requesters; every transaction places
// a and stop D cycles after b, with D inside the intersected a and stop windows.
module intersect_seq_ctrl
  import intersect_seq_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 3,
  parameter int unsigned A_MIN = 1,
  parameter int unsigned A_MAX = 2,
  parameter int unsigned S_MIN = 2,
  parameter int unsigned S_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N*DW-1:0] dly,
  output logic [N-1:0]  gnt,
  output logic          err,
  output logic          done,
  output logic          busy,
  output logic          start,
  output logic          b,
  output logic          a,
  output logic          stop
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned LO = win_lo(A_MIN, S_MIN);
  localparam int unsigned HI = win_hi(A_MAX, S_MAX);

  seq_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] arb_idx;
  logic [N-1:0]  arb_gnt;
  logic          arb_en;
  logic [DW-1:0] d_q;
  logic [DW-1:0] cnt;
  logic [DW-1:0] win_d;
  logic          win_legal;

  // The err cycle after a rejected grant is kept free of arbitration.
  assign arb_en = (state == ST_IDLE) && !err && !rst;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req (req),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign gnt = arb_gnt;

  always_comb begin
    win_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (arb_idx == PW'(i)) win_d = DW'(dly >> (i * DW));
    end
  end

  assign win_legal = dly_legal(32'(win_d), LO, HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= PW'(N - 1);
      cnt   <= '0;
      d_q   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      start <= 1'b0;
      b     <= 1'b0;
      a     <= 1'b0;
      stop  <= 1'b0;
    end else begin
      err   <= 1'b0;
      done  <= 1'b0;
      start <= 1'b0;
      b     <= 1'b0;
      a     <= 1'b0;
      stop  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|arb_gnt) begin
            ptr <= arb_idx;
            d_q <= win_d;
            if (win_legal) begin
              state <= ST_START;
              start <= 1'b1;
              busy  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_START: begin
          state <= ST_B;
          b     <= 1'b1;
          cnt   <= d_q - DW'(1);
        end
        ST_B: begin
          if (cnt == '0) begin
            state <= ST_END;
            a     <= 1'b1;
            stop  <= 1'b1;
            done  <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        // Leaving on cnt==1 puts END exactly D cycles after b; cnt settles at 0.
        ST_WAIT: begin
          cnt <= cnt - DW'(1);
          if (cnt == DW'(1)) begin
            state <= ST_END;
            a     <= 1'b1;
            stop  <= 1'b1;
            done  <= 1'b1;
          end
        end
        ST_END: begin
          state <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intersect_seq_ctrl.sv
// Bench for intersect_seq_ctrl: timeline reference model checked every cycle,
// directed vector table, and hand sequences for arbitration, reset and window corners.
module tb_intersect_seq_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 3;
  localparam int unsigned DLW = N * DW;
  localparam int unsigned P_A_MIN = 1, P_A_MAX = 2, P_S_MIN = 2, P_S_MAX = 3;
  localparam int unsigned W_A_MIN = 1, W_A_MAX = 3, W_S_MIN = 1, W_S_MAX = 3;
  localparam int unsigned LO  = (P_A_MIN > P_S_MIN) ? P_A_MIN : P_S_MIN;
  localparam int unsigned HI  = (P_A_MAX < P_S_MAX) ? P_A_MAX : P_S_MAX;
  localparam int unsigned LO2 = (W_A_MIN > W_S_MIN) ? W_A_MIN : W_S_MIN;
  localparam int unsigned HI2 = (W_A_MAX < W_S_MAX) ? W_A_MAX : W_S_MAX;
  localparam int unsigned R   = 64;

  logic clk, rst;
  logic [N-1:0]   req, gnt, req2, gnt2;
  logic [DLW-1:0] dly, dly2;
  logic err, done, busy, start, b, a, stop;
  logic err2, done2, busy2, start2, b2, a2, stop2;

  intersect_seq_ctrl #(.N(N), .DW(DW), .A_MIN(P_A_MIN), .A_MAX(P_A_MAX),
                       .S_MIN(P_S_MIN), .S_MAX(P_S_MAX)) u_dut (
    .clk(clk), .rst(rst), .req(req), .dly(dly), .gnt(gnt), .err(err), .done(done),
    .busy(busy), .start(start), .b(b), .a(a), .stop(stop));

  intersect_seq_ctrl #(.N(N), .DW(DW), .A_MIN(W_A_MIN), .A_MAX(W_A_MAX),
                       .S_MIN(W_S_MIN), .S_MAX(W_S_MAX)) u_wide (
    .clk(clk), .rst(rst), .req(req2), .dly(dly2), .gnt(gnt2), .err(err2), .done(done2),
    .busy(busy2), .start(start2), .b(b2), .a(a2), .stop(stop2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic err, done, busy, start, b, a, stop;
  } obs_t;

  typedef struct {
    logic [N-1:0]   req;
    logic [DLW-1:0] dly;
    logic [N-1:0]   exp_gnt;
    logic           exp_err;
    int unsigned    exp_lat;
  } vec_t;

  obs_t        exp_q [R];
  int unsigned cyc, free_at, m_ptr;
  int unsigned n_checks, n_fail;
  vec_t        vecs [7];

  function automatic logic [5:0] sl(input int unsigned x);
    return 6'(x % R);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Timeline model: a grant books every later channel event at absolute cycles.
  task automatic model_step();
    obs_t act;
    int unsigned k, win, d, rq;
    logic found;
    cyc++;
    k = cyc;
    if (!rst && k >= free_at && req != '0) begin
      rq = 32'(req);
      found = 1'b0;
      win = 0;
      for (int unsigned off = 1; off <= N; off++) begin
        if (!found && (((rq >> ((m_ptr + off) % N)) & 1) != 0)) begin
          win = (m_ptr + off) % N;
          found = 1'b1;
        end
      end
      d = (32'(dly) >> (win * DW)) & ((1 << DW) - 1);
      exp_q[sl(k)].gnt = N'(1 << win);
      m_ptr = win;
      if (d != 0 && d >= LO && d <= HI) begin
        exp_q[sl(k + 1)].start = 1'b1;
        exp_q[sl(k + 2)].b = 1'b1;
        exp_q[sl(k + 2 + d)].a = 1'b1;
        exp_q[sl(k + 2 + d)].stop = 1'b1;
        exp_q[sl(k + 2 + d)].done = 1'b1;
        for (int unsigned t = k + 1; t <= k + 3 + d; t++) exp_q[sl(t)].busy = 1'b1;
        free_at = k + 4 + d;
      end else begin
        exp_q[sl(k + 1)].err = 1'b1;
        free_at = k + 2;
      end
    end
    act = {gnt, err, done, busy, start, b, a, stop};
    check("cycle_outputs", 32'(act), 32'(exp_q[sl(k)]));
    exp_q[sl(k)] = '0;
    if (rst) begin
      for (int unsigned t = k + 1; t <= k + 12; t++) exp_q[sl(t)] = '0;
      m_ptr = N - 1;
      free_at = k + 1;
    end
  endtask

  task automatic smp();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req = '0; req2 = '0; rst = 1'b1;
    smp();
    adv();
    rst = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      smp();
      adv();
    end
  endtask

  task automatic wait_gnt();
    for (int unsigned w = 0; (w < 30) && (gnt == '0); w++) begin
      adv();
      smp();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned lat;
    reset_dut();
    req = v.req; dly = v.dly;
    smp();
    check("vec_gnt", 32'(gnt), 32'(v.exp_gnt));
    adv();
    req = '0;
    smp();
    check("vec_err", 32'(err), 32'(v.exp_err));
    check("vec_start", 32'(start), 32'(!v.exp_err));
    if (!v.exp_err) begin
      adv(); smp();
      check("vec_b", 32'({b, a, stop}), 32'(3'b100));
      lat = 2;
      while (!done && lat < 12) begin
        adv(); smp();
        lat++;
      end
      check("vec_done_lat", lat, v.exp_lat);
      check("vec_a_stop", 32'({a, stop, busy}), 32'(3'b111));
      adv(); smp();
      check("vec_gap", 32'({busy, start, b, a, stop, done}), 32'(6'b100000));
      adv(); smp();
      check("vec_idle", 32'(busy), 0);
    end
    adv();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required end of test");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rr_exp [5];
    int unsigned  wide_d [4];
    int unsigned  prev, acc, lat, dd;
    logic         legal;

    foreach (exp_q[i]) exp_q[i] = '0;
    cyc = 0; free_at = 0; m_ptr = N - 1; n_checks = 0; n_fail = 0;
    rst = 1'b1; req = '0; dly = '0; req2 = '0; dly2 = '0;

    vecs[0] = '{req: 4'b0001, dly: 12'h002, exp_gnt: 4'b0001, exp_err: 1'b0, exp_lat: 4};
    vecs[1] = '{req: 4'b0100, dly: 12'h0C0, exp_gnt: 4'b0100, exp_err: 1'b1, exp_lat: 0};
    vecs[2] = '{req: 4'b1000, dly: 12'h400, exp_gnt: 4'b1000, exp_err: 1'b0, exp_lat: 4};
    vecs[3] = '{req: 4'b0110, dly: 12'h090, exp_gnt: 4'b0010, exp_err: 1'b0, exp_lat: 4};
    vecs[4] = '{req: 4'b0001, dly: 12'h000, exp_gnt: 4'b0001, exp_err: 1'b1, exp_lat: 0};
    vecs[5] = '{req: 4'b1000, dly: 12'h200, exp_gnt: 4'b1000, exp_err: 1'b1, exp_lat: 0};
    vecs[6] = '{req: 4'b0011, dly: 12'h02A, exp_gnt: 4'b0001, exp_err: 1'b0, exp_lat: 4};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    wide_d = '{1, 3, 0, 2};

    @(posedge clk); #1;
    smp();
    check("reset_state", 32'({gnt, err, done, busy, start, b, a, stop}), 0);
    check("reset_state_wide", 32'({gnt2, err2, done2, busy2, start2, b2, a2, stop2}), 0);
    adv();
    rst = 1'b0;

    for (int unsigned i = 0; i < 7; i++) run_vec(vecs[i]);

    // All four requesting continuously: strict rotation, 6 cycles apart.
    reset_dut();
    req = 4'b1111; dly = 12'h492;
    smp();
    wait_gnt();
    check("rr_gnt0", 32'(gnt), 32'(rr_exp[0]));
    prev = cyc;
    for (int unsigned g = 1; g < 5; g++) begin
      adv(); smp();
      wait_gnt();
      check("rr_gnt", 32'(gnt), 32'(rr_exp[g]));
      check("rr_spacing", cyc - prev, 6);
      prev = cyc;
    end
    adv(); req = '0;
    drain(10);

    // Illegal D then a legal request two cycles later.
    reset_dut();
    req = 4'b0100; dly = 12'h0C0;
    smp();
    check("ill_gnt", 32'(gnt), 32'(4'b0100));
    adv(); req = 4'b0001; dly = 12'h002;
    smp();
    check("ill_err", 32'({err, start, gnt}), 32'(6'b100000));
    adv(); smp();
    check("ill_next_gnt", 32'({gnt, err}), 32'(5'b00010));
    adv(); req = '0;
    drain(8);

    // Reset during WAIT: no done, pending requester 0 granted first afterwards.
    reset_dut();
    req = 4'b0001; dly = 12'h002;
    smp();
    check("rw_gnt", 32'(gnt), 32'(4'b0001));
    adv(); smp();
    adv(); smp();
    check("rw_b", 32'(b), 1);
    adv(); rst = 1'b1;
    smp();
    check("rw_wait_busy", 32'({busy, done}), 32'(2'b10));
    adv();
    smp();
    check("rw_all_zero", 32'({gnt, err, done, busy, start, b, a, stop}), 0);
    adv(); rst = 1'b0;
    smp();
    check("rw_regrant", 32'({gnt, done}), 32'(5'b00010));
    adv(); req = '0;
    drain(10);

    // 0011 with D1 illegal: 0 completes, 1 errors, 0 wins again.
    reset_dut();
    req = 4'b0011; dly = 12'h02A;
    smp();
    check("mix_gnt0", 32'(gnt), 32'(4'b0001));
    prev = cyc;
    adv(); smp();
    wait_gnt();
    check("mix_gnt1", 32'(gnt), 32'(4'b0010));
    check("mix_gap1", cyc - prev, 6);
    prev = cyc;
    adv(); smp();
    check("mix_err1", 32'({err, start}), 32'(2'b10));
    wait_gnt();
    check("mix_gnt0_again", 32'(gnt), 32'(4'b0001));
    check("mix_gap2", cyc - prev, 2);
    adv(); req = '0;
    drain(10);

    // Wider window instance: D=1 skips WAIT, D=3 at top edge, D=0 rejected.
    for (int unsigned i = 0; i < 4; i++) begin
      dd = wide_d[i];
      legal = (dd != 0) && (dd >= LO2) && (dd <= HI2);
      reset_dut();
      req2 = 4'b0010; dly2 = DLW'(dd << DW);
      smp();
      check("w_gnt", 32'(gnt2), 32'(4'b0010));
      adv(); req2 = '0;
      smp();
      check("w_err", 32'(err2), 32'(!legal));
      check("w_start", 32'(start2), 32'(legal));
      if (legal) begin
        adv(); smp();
        check("w_b", 32'({b2, a2, stop2}), 32'(3'b100));
        lat = 2;
        while (!done2 && lat < 12) begin
          adv(); smp();
          lat++;
        end
        check("w_done_lat", lat, dd + 2);
        check("w_a_stop", 32'({a2, stop2}), 32'(2'b11));
      end
      adv();
      drain(4);
    end

    // Randomized traffic with occasional resets.
    for (int unsigned i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = N'($urandom_range(0, (1 << N) - 1));
        acc = 0;
        for (int unsigned j = 0; j < N; j++)
          acc = acc | (($urandom_range(0, 1) != 0 ? 2 : $urandom_range(0, 7)) << (j * DW));
        dly = DLW'(acc);
      end
      rst = ($urandom_range(0, 199) == 0);
      smp();
      adv();
    end
    rst = 1'b0; req = '0;
    drain(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intersect_seq_ctrl.md
# intersect_seq_ctrl

Controller that shares one start/a/b/stop handshake channel among N requesters. It drives each transaction so the channel always satisfies the team's intersect-window contract: `start` rises, then `b` one cycle later, then `a` and `stop` together after a common delay D. D must lie in both the `a` window and the `b`-to-`stop` window. Requests whose D falls outside the intersection are rejected with an error pulse and never reach the channel.

## Interface
- `N`, 4: number of requesters (2..8).
- `DW`, 3: width of each requested delay field.
- `A_MIN`, 1: minimum cycles from `b` to `a`.
- `A_MAX`, 2: maximum cycles from `b` to `a`.
- `S_MIN`, 2: minimum cycles from `b` to `stop`.
- `S_MAX`, 3: maximum cycles from `b` to `stop`.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester request level; held until granted.
- `dly`  in  N*DW  packed delay D per requester; slice i = `dly[i*DW +: DW]`.
- `gnt`  out  N  one-hot, one-cycle grant pulse.
- `err`  out  1  one-cycle pulse: granted request had an illegal D.
- `done`  out  1  one-cycle pulse: transaction completed.
- `busy`  out  1  high from the start cycle through the gap cycle.
- `start`, `b`, `a`, `stop`  out  1 each  channel outputs, all registered.

## Operation
- Legal window: LO = max(A_MIN,S_MIN), HI = min(A_MAX,S_MAX). Defaults give LO = HI = 2.
  - If LO > HI, no D is legal, and every request gets `err`.
- FSM states: IDLE, START, B, WAIT, END, GAP.
- IDLE, with any `req` set:
  - Round-robin arbiter picks a winner, searching from `ptr+1`. `gnt` pulses that cycle.
  - D is latched and `ptr` is updated to the winner.
  - D in [LO,HI]: go to START.
  - Otherwise: `err` pulses on the next cycle, the FSM stays in IDLE, and the channel does not move.
- START: `start`=1 for exactly one cycle. `start` is 0 in every other state, so every start is a rising edge.
- B: `b`=1 for one cycle. A down-counter is loaded with D−1.
- WAIT: counter decrements each cycle and exits at 0.
  - With D=1, the FSM goes from B directly to END.
- END: `a`=1, `stop`=1 and `done`=1 in the same cycle.
- GAP: all channel outputs 0 for one cycle, then IDLE. Back-to-back transactions therefore always see a clean `start` rise.
- `req` changes during a transaction have no effect. Arbitration is evaluated only in IDLE.
- Reset, including mid-transaction: state=IDLE, `ptr`=N−1 (so requester 0 has first priority), counter=0.
  - All outputs (`gnt`, `err`, `done`, `busy`, `start`, `b`, `a`, `stop`) are 0 at the first edge with `rst`=1.
  - No `done` is emitted for an aborted transaction.
- D arithmetic is unsigned DW-bit. D=0 is always illegal. The counter is DW bits wide and never wraps.

## Timing
- Grant at edge G (IDLE, legal D):
  - `start` at G+1.
  - `b` at G+2.
  - `a`/`stop`/`done` at G+2+D.
  - GAP at G+3+D.
  - Earliest next `gnt` at G+4+D.
- Illegal D: `gnt` at G, `err` at G+1, next `gnt` at G+2 at the earliest.
- `busy` is high over G+1 .. G+3+D inclusive.
- Channel outputs come directly from flops. There is no combinational path from `req`/`dly` to the channel.
- `gnt` is combinational from `req` and `ptr` in IDLE.

## Structure
- Package `intersect_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - functions `win_lo(A_MIN,S_MIN)` and `win_hi(A_MAX,S_MAX)`;
  - the legality check `dly_legal(d,lo,hi)`.
- Sub-module `rr_arbiter` (parameter N; ports `req`, `ptr`, `en`, `gnt`, `idx`) is the natural split. The FSM, counter and registers stay in the top.
- Verification binds the team's intersect assertion (`$rose(start) |=> (##[A_MIN:A_MAX] a) intersect (b ##[S_MIN:S_MAX] stop)`) to the top. It must never fail.

## Test plan
- Reset, then `req`=0001, D0=2 → `gnt`=0001 at G; `start` at G+1; `b` at G+2; `a`/`stop`/`done` at G+4; GAP at G+5; assertion passes.
- `req`=1111, all D=2, held continuously → grants in order 0001, 0010, 0100, 1000, 0001. Each `gnt` is 6 cycles after the previous one.
- `req`=0100, D2=3 with defaults → `gnt`=0100, `err` at G+1, no `start`; the next legal request is granted at G+2.
- Parameters A=1..3, S=1..3, D=1 → `b` at G+2, `a`/`stop` at G+3; WAIT is skipped.
- `rst` asserted in the WAIT state → all outputs 0 at the next edge, no `done`; a `req`=0001 that is still pending is granted first after reset.
- `req`=0011 with D0=2 and D1=5 → requester 0 completes; requester 1 gets `err`; `ptr`=1, so requester 0 wins the next round-robin tie.
